// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver feeding a small receive FIFO.
// Bits are sampled at mid-bit from a 2-flop synchronised copy of rxd.
module uart_rx #(
  parameter int CLKS_PER_BIT = 208,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic          sync1_q, rxs_q;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          push_s, pop_s, wr_en_s, full_s, empty_s;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rxs_q   <= sync1_q;
    end
  end

  // Receive FSM next-state: start detect, mid-bit sampling, stop check.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push_s      = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          timer_d = {TW{1'b0}};
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (timer_q == HALF_LAST) begin
          timer_d   = {TW{1'b0}};
          bit_idx_d = 3'd0;
          if (rxs_q) begin
            state_d = S_IDLE;   // glitch, not a real start bit
          end else begin
            state_d = S_DATA;
          end
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      S_DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d   = {TW{1'b0}};
          shift_d   = {rxs_q, shift_q[7:1]};   // LSB arrives first
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      S_STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = {TW{1'b0}};
          if (rxs_q) begin
            push_s  = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      S_BREAK: begin
        // Hold here while the line stays low so a break reports only once.
        if (rxs_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BREAK;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_s   = !empty_s && rd_ready;
  // A full FIFO still accepts the byte when the head is popped in the same cycle.
  assign wr_en_s = push_s && (!full_s || pop_s);

  // FIFO next-state: write at the tail, advance pointers, flag dropped bytes.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    overrun_d = push_s && full_s && !pop_s;
    if (wr_en_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = shift_q;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // State, datapath, FIFO and pulse-output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      timer_q     <= {TW{1'b0}};
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= {(AW + 1){1'b0}};
      rd_ptr_q    <= {(AW + 1){1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
    end
  end

  assign rd_data   = mem_q[rd_ptr_q[AW-1:0]];
  assign rd_valid  = !empty_s;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level reference model plus directed
// scenarios and a randomized phase.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  // Start edge -> push edge: 2 sync clocks + 9.5 bit times + 1.
  localparam int LAT   = 2 + CPB / 2 + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rxd = 1'b1;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, frame_err, overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  typedef struct {
    int         at;
    logic [7:0] data;
    bit         good;
  } ev_t;

  ev_t        evq[$];     // expected stop-sample outcomes, by clock edge
  logic [7:0] mq[$];      // expected FIFO contents, head first
  logic [7:0] plog[$];    // bytes the model saw popped
  logic       ready_prev = 1'b0;
  int         n0;
  bit         pop_occ, efe, eov;
  ev_t        e_chk, e_main;
  bit         rand_done;

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the frame-level model.
  always @(negedge clk) begin
    if (reset) begin
      mq.delete();
      evq.delete();
      ready_prev = 1'b0;
      chk("reset rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("reset rd_data", {24'd0, rd_data}, 32'd0);
      chk("reset frame_err", {31'd0, frame_err}, 32'd0);
      chk("reset overrun", {31'd0, overrun}, 32'd0);
    end else begin
      n0      = mq.size();
      pop_occ = (n0 > 0) && ready_prev;
      efe     = 1'b0;
      eov     = 1'b0;
      if (pop_occ) plog.push_back(mq.pop_front());
      while (evq.size() > 0 && evq[0].at <= cyc) begin
        e_chk = evq.pop_front();
        if (e_chk.at == cyc) begin
          if (!e_chk.good) efe = 1'b1;
          else if (n0 < DEPTH || pop_occ) mq.push_back(e_chk.data);
          else eov = 1'b1;
        end
      end
      chk("rd_valid", {31'd0, rd_valid}, {31'd0, mq.size() > 0});
      if (mq.size() > 0) chk("rd_data", {24'd0, rd_data}, {24'd0, mq[0]});
      chk("frame_err", {31'd0, frame_err}, {31'd0, efe});
      chk("overrun", {31'd0, overrun}, {31'd0, eov});
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      ready_prev = rd_ready;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick(1);
  endtask

  // Drive one 8N1 frame starting now; registers the expected outcome.
  task automatic send_frame(input logic [7:0] d, input bit good);
    ev_t e;
    rxd    = 1'b0;
    e.at   = cyc + LAT;
    e.data = d;
    e.good = good;
    evq.push_back(e);
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      tick(CPB);
    end
    rxd = good;
    tick(CPB);
    rxd = 1'b1;
  endtask

  task automatic chk_log(input string name, input int n, input logic [63:0] exp);
    chk({name, " count"}, plog.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < plog.size()) chk(name, {24'd0, plog[i]}, {24'd0, exp[8*i +: 8]});
    end
    plog.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int f, t5, fe0, ov0, gap;
    logic [7:0] b77, d;
    bit good;
    b77 = 8'h77;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick(4);

    // 1: single byte, exact latency
    f = cyc;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_until(f + LAT - 1);
        chk("t1 valid before push", {31'd0, rd_valid}, 32'd0);
        tick(1);
        chk("t1 valid at push", {31'd0, rd_valid}, 32'd1);
        chk("t1 data", {24'd0, rd_data}, 32'hA5);
        chk("t1 no frame_err", {31'd0, frame_err}, 32'd0);
        chk("t1 no overrun", {31'd0, overrun}, 32'd0);
      end
    join
    tick(CPB);
    rd_ready = 1'b1;
    tick(4);
    chk_log("t1 pop", 1, 64'hA5);

    // 2: back-to-back with consumer ready
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    send_frame(8'h3C, 1'b1);
    tick(2 * CPB);
    chk_log("t2 order", 4, 64'h3C55FF00);
    chk("t2 empty", {31'd0, rd_valid}, 32'd0);

    // 3: overrun on the fifth byte
    rd_ready = 1'b0;
    ov0 = ov_cnt;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    tick(CPB);
    chk("t3 overrun pulses", ov_cnt - ov0, 32'd1);
    rd_ready = 1'b1;
    tick(8);
    chk_log("t3 pops", 4, 64'h04030201);
    rd_ready = 1'b0;

    // 4: glitch, framing error, break
    fe0 = fe_cnt;
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(3 * CPB);
    chk("t4 glitch frame_err", fe_cnt - fe0, 32'd0);
    chk("t4 glitch no data", {31'd0, rd_valid}, 32'd0);
    send_frame(8'h81, 1'b0);
    tick(2 * CPB);
    chk("t4 bad stop frame_err", fe_cnt - fe0, 32'd1);
    chk("t4 bad stop no data", {31'd0, rd_valid}, 32'd0);
    fe0 = fe_cnt;
    rxd = 1'b0;
    e_main.at = cyc + LAT;
    e_main.data = 8'h00;
    e_main.good = 1'b0;
    evq.push_back(e_main);
    tick(30 * CPB);
    rxd = 1'b1;
    tick(2 * CPB);
    chk("t4 break single frame_err", fe_cnt - fe0, 32'd1);
    send_frame(8'h42, 1'b1);
    tick(CPB);
    rd_ready = 1'b1;
    tick(4);
    chk_log("t4 after break", 1, 64'h42);
    rd_ready = 1'b0;

    // 5: full FIFO with pop coinciding with the push
    ov0 = ov_cnt;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    t5 = cyc + LAT;
    fork
      send_frame(8'h05, 1'b1);
      begin
        wait_until(t5 - 1);
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
      end
    join
    tick(CPB);
    chk("t5 no overrun", ov_cnt - ov0, 32'd0);
    chk("t5 still valid", {31'd0, rd_valid}, 32'd1);
    chk_log("t5 coincident pop", 1, 64'h01);
    rd_ready = 1'b1;
    tick(8);
    chk_log("t5 drain", 4, 64'h05040302);
    rd_ready = 1'b0;

    // 6: reset in the middle of a frame
    send_frame(8'hA1, 1'b1);
    send_frame(8'hB2, 1'b1);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rxd = b77[i];
      tick(CPB);
    end
    rxd = b77[3];
    tick(CPB / 2);
    chk("t6 queued before reset", {31'd0, rd_valid}, 32'd1);
    reset = 1'b1;
    rxd = 1'b1;
    #1;
    chk("t6 async rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("t6 async rd_data", {24'd0, rd_data}, 32'd0);
    tick(3);
    reset = 1'b0;
    tick(2 * CPB);
    plog.delete();
    send_frame(8'h12, 1'b1);
    tick(CPB);
    rd_ready = 1'b1;
    tick(4);
    chk_log("t6 after reset", 1, 64'h12);
    rd_ready = 1'b0;

    // Randomized frames, gaps, stop bits and consumer readiness
    rand_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          d = 8'($urandom_range(0, 255));
          good = ($urandom_range(0, 5) != 0);
          send_frame(d, good);
          gap = good ? $urandom_range(0, 20) : $urandom_range(CPB, 3 * CPB);
          tick(gap);
        end
        tick(2 * CPB);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          rd_ready = ($urandom_range(0, 1) == 1);
          tick(1);
        end
      end
    join
    rd_ready = 1'b1;
    tick(10);
    chk("random drained", {31'd0, rd_valid}, 32'd0);
    plog.delete();
    rd_ready = 1'b0;
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
